// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the MMU, the secondary DMA master and the memory controller.
// The arbiter uses the slave view; the driving side (MMU/DMA/memory model) uses master.
interface mem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_lock;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_we;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        owner;

  modport slave (
    input  cpu_req, cpu_lock, cpu_addr, cpu_wdata, cpu_we,
    input  dma_req, dma_addr, dma_wdata, dma_we,
    input  mem_rdata, mem_busy,
    output cpu_rdata, cpu_stall, dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_we, owner
  );

  modport master (
    output cpu_req, cpu_lock, cpu_addr, cpu_wdata, cpu_we,
    output dma_req, dma_addr, dma_wdata, dma_we,
    output mem_rdata, mem_busy,
    input  cpu_rdata, cpu_stall, dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_we, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory controller between the CPU (combinational pass-through) and a
// DMA master that gets single-transaction grants with bounded starvation.
//
// state   | meaning
// CPU_OWN | CPU drives memory; DMA waits for an idle slot or the run limit
// DMA_OWN | one DMA transaction in flight; CPU stalled until memory is free
module mem_bus_arbiter #(
  parameter int MAX_CPU_RUN = 8,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    bus
);

  typedef enum logic {CPU_OWN = 1'b0, DMA_OWN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CPU_RUN - 1);
  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(MAX_CPU_RUN);

  state_t             r_state;
  logic [CNT_W-1:0]   r_run_cnt;
  logic               r_dma_ack;
  logic [31:0]        r_dma_rdata;

  state_t             w_next_state;
  logic [CNT_W-1:0]   w_run_cnt_nxt;
  logic               w_dma_done;
  logic               w_switch;
  logic               w_cpu_done;
  logic               w_cpu_stall;
  logic [31:0]        w_mem_addr;
  logic [31:0]        w_mem_wdata;
  logic               w_mem_we;

  assign w_cpu_done = bus.cpu_req & ~bus.mem_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CPU_OWN;
      r_run_cnt   <= '0;
      r_dma_ack   <= 1'b0;
      r_dma_rdata <= '0;
    end else begin
      r_state   <= w_next_state;
      r_run_cnt <= w_run_cnt_nxt;
      r_dma_ack <= w_dma_done;
      if (w_dma_done) r_dma_rdata <= bus.mem_rdata;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_run_cnt_nxt = r_run_cnt;
    w_dma_done    = 1'b0;
    w_switch      = 1'b0;
    w_cpu_stall   = 1'b0;
    w_mem_addr    = bus.cpu_addr;
    w_mem_wdata   = bus.cpu_wdata;
    w_mem_we      = bus.cpu_we & bus.cpu_req;
    case (r_state)
      CPU_OWN: begin
        w_cpu_stall = bus.cpu_req & bus.mem_busy;
        // A held request is ignored during the ack cycle so the CPU always gets a slot.
        w_switch = bus.dma_req && !r_dma_ack && !bus.mem_busy && !bus.cpu_lock &&
                   (!bus.cpu_req || (w_cpu_done && (r_run_cnt >= RUN_LAST)));
        if (!bus.dma_req) begin
          w_run_cnt_nxt = '0;
        end else if (w_switch) begin
          w_next_state  = DMA_OWN;
          w_run_cnt_nxt = '0;
        end else if (w_cpu_done && (r_run_cnt != RUN_MAX)) begin
          w_run_cnt_nxt = r_run_cnt + 1'b1;
        end
      end
      DMA_OWN: begin
        w_cpu_stall = bus.cpu_req;
        w_mem_addr  = bus.dma_addr;
        w_mem_wdata = bus.dma_wdata;
        w_mem_we    = bus.dma_we;
        if (!bus.dma_req) w_run_cnt_nxt = '0;
        if (!bus.mem_busy) begin
          w_dma_done   = 1'b1;
          w_next_state = CPU_OWN;
        end
      end
    endcase
  end

  assign bus.owner     = (r_state == DMA_OWN);
  assign bus.cpu_stall = w_cpu_stall;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = w_mem_we;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected CPU/DMA read data,
// a negedge monitor pops and compares whenever the arbiter completes an access.
module tb_mem_bus_arbiter;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.MAX_CPU_RUN(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: completed CPU accesses and DMA acks are matched against the queues.
  always @(negedge clk) begin
    if (bus.dma_ack === 1'b1) begin
      if (dma_q.size() == 0) begin
        n_total++;
        $display("FAIL dma_ack_unexpected: got ack with rdata 0x%08h expected no ack at %0t", bus.dma_rdata, $time);
      end else begin
        check("dma_rdata", bus.dma_rdata, dma_q.pop_front());
      end
    end
    if (bus.cpu_req === 1'b1 && bus.cpu_stall === 1'b0) begin
      if (cpu_q.size() == 0) begin
        n_total++;
        $display("FAIL cpu_done_unexpected: got completion expected stall at %0t", $time);
      end else begin
        check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_lock = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0;
    bus.dma_req = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_we = 1'b0;
    bus.mem_rdata = '0; bus.mem_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mid();
    check("rst_owner", 32'(bus.owner), 32'd0);
    check("rst_dma_ack", 32'(bus.dma_ack), 32'd0);
    check("rst_dma_rdata", bus.dma_rdata, 32'd0);
    check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);

    // CPU pass-through read
    tick();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h100; bus.mem_rdata = 32'hDEADBEEF;
    cpu_q.push_back(32'hDEADBEEF);
    mid();
    check("t1_stall", 32'(bus.cpu_stall), 32'd0);
    check("t1_owner", 32'(bus.owner), 32'd0);
    check("t1_dma_ack", 32'(bus.dma_ack), 32'd0);
    check("t1_mem_addr", bus.mem_addr, 32'h100);
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h104;
    mid();
    check("idle_mem_we", 32'(bus.mem_we), 32'd0);
    check("idle_mem_addr", bus.mem_addr, 32'h104);

    // Idle CPU, single DMA read
    tick();
    bus.cpu_we = 1'b0; bus.dma_req = 1'b1; bus.dma_addr = 32'h2000; bus.dma_we = 1'b0;
    bus.mem_rdata = 32'h12345678;
    mid();
    check("t2_owner_req", 32'(bus.owner), 32'd0);
    tick();
    dma_q.push_back(32'h12345678);
    mid();
    check("t2_owner_grant", 32'(bus.owner), 32'd1);
    check("t2_mem_addr", bus.mem_addr, 32'h2000);
    check("t2_mem_we", 32'(bus.mem_we), 32'd0);
    check("t2_no_early_ack", 32'(bus.dma_ack), 32'd0);
    tick();
    mid();
    check("t2_ack", 32'(bus.dma_ack), 32'd1);
    check("t2_owner_back", 32'(bus.owner), 32'd0);
    tick();
    bus.dma_req = 1'b0;
    mid();
    check("t2_no_regrant", 32'(bus.owner), 32'd0);
    check("t2_ack_one_cycle", 32'(bus.dma_ack), 32'd0);

    // Busy CPU: exactly MAX_CPU_RUN completions before the forced switch
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1; bus.dma_addr = 32'h3000;
      end
      bus.cpu_addr  = 32'h400 + 32'(4 * i);
      bus.mem_rdata = 32'hC000_0000 + 32'(i);
      cpu_q.push_back(bus.mem_rdata);
      mid();
      check("t3_run_owner", 32'(bus.owner), 32'd0);
    end
    tick();
    bus.mem_rdata = 32'hAAAA5555;
    dma_q.push_back(32'hAAAA5555);
    mid();
    check("t3_grant_owner", 32'(bus.owner), 32'd1);
    check("t3_grant_stall", 32'(bus.cpu_stall), 32'd1);
    check("t3_grant_addr", bus.mem_addr, 32'h3000);
    tick();
    bus.dma_req = 1'b0; bus.mem_rdata = 32'hC000_0008;
    cpu_q.push_back(32'hC000_0008);
    mid();
    check("t3_ack", 32'(bus.dma_ack), 32'd1);
    check("t3_cpu_resume", 32'(bus.cpu_stall), 32'd0);

    // Lock holds off DMA while run_cnt saturates; then busy memory delays the switch
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin
        bus.cpu_lock = 1'b1; bus.dma_req = 1'b1; bus.dma_addr = 32'h5000;
      end
      bus.mem_rdata = 32'hB000_0000 + 32'(i);
      cpu_q.push_back(bus.mem_rdata);
      mid();
      if (i == 19) check("t4_locked_owner", 32'(bus.owner), 32'd0);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      if (j == 0) begin
        bus.cpu_lock = 1'b0; bus.mem_busy = 1'b1;
      end
      mid();
      check("t4_busy_owner", 32'(bus.owner), 32'd0);
      check("t4_busy_stall", 32'(bus.cpu_stall), 32'd1);
    end
    tick();
    bus.mem_busy = 1'b0; bus.mem_rdata = 32'hB000_0099;
    cpu_q.push_back(32'hB000_0099);
    mid();
    check("t4_last_cpu_owner", 32'(bus.owner), 32'd0);
    tick();
    bus.mem_rdata = 32'h77778888;
    dma_q.push_back(32'h77778888);
    mid();
    check("t4_switch_owner", 32'(bus.owner), 32'd1);
    check("t4_switch_addr", bus.mem_addr, 32'h5000);
    tick();
    bus.dma_req = 1'b0; bus.cpu_req = 1'b0;
    mid();
    check("t4_ack", 32'(bus.dma_ack), 32'd1);

    // Lock with idle CPU blocks the switch
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        bus.cpu_lock = 1'b1; bus.dma_req = 1'b1; bus.dma_addr = 32'h6000;
      end
      mid();
      check("t5_lock_owner", 32'(bus.owner), 32'd0);
    end
    tick();
    bus.cpu_lock = 1'b0; bus.mem_rdata = 32'h0BADF00D;
    mid();
    check("t5_unlock_owner", 32'(bus.owner), 32'd0);
    tick();
    dma_q.push_back(32'h0BADF00D);
    mid();
    check("t5_switch_owner", 32'(bus.owner), 32'd1);
    check("t5_switch_addr", bus.mem_addr, 32'h6000);
    tick();
    bus.dma_req = 1'b0;
    mid();
    check("t5_ack", 32'(bus.dma_ack), 32'd1);

    // Reset during a busy DMA write aborts it without an ack
    tick();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h7000; bus.dma_wdata = 32'hFEEDFACE;
    mid();
    check("t6_owner_req", 32'(bus.owner), 32'd0);
    tick();
    bus.mem_busy = 1'b1;
    mid();
    check("t6_owner_grant", 32'(bus.owner), 32'd1);
    check("t6_mem_we", 32'(bus.mem_we), 32'd1);
    check("t6_mem_wdata", bus.mem_wdata, 32'hFEEDFACE);
    tick();
    mid();
    check("t6_busy_no_ack", 32'(bus.dma_ack), 32'd0);
    tick();
    rst = 1'b1;
    mid();
    check("t6_pre_rst_owner", 32'(bus.owner), 32'd1);
    tick();
    rst = 1'b0; bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.mem_busy = 1'b0;
    mid();
    check("t6_rst_owner", 32'(bus.owner), 32'd0);
    check("t6_rst_dma_ack", 32'(bus.dma_ack), 32'd0);
    check("t6_rst_dma_rdata", bus.dma_rdata, 32'd0);
    tick();
    mid();
    check("t6_post_rst_ack", 32'(bus.dma_ack), 32'd0);

    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("dma_q_drained", 32'(dma_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
